i2c_target_rx: RTL

- I2C target (responder) for the team's I2C master/LCD path; sits on the same scl/sda pair the master drives.
- Models a PCF8574-style backpack in simulation and on the bench.
- Decodes START/STOP, matches a 7-bit address, ACKs, and delivers each written byte on a parallel strobe interface.
- Serves reads from a parallel input byte. Oversampled entirely in the clk domain; no logic clocked by scl.

---
 rtl/i2c_target_rx.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_rx.sv
// Oversampled I2C target: START/STOP decode, 7-bit address match, byte rx/tx.
// Define GLITCH_FILTER_EN for a 3-sample majority filter on scl/sda.
module i2c_target_rx #(
  parameter logic [6:0] TGT_ADDR    = 7'h27,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] nack_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK, S_WBYTE,
    S_RBYTE, S_MACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_f, sda_f, scl_p_q, sda_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  logic       scl_f_q, sda_f_q;
  logic       scl_n, sda_n;

  assign scl_n = scl_sync_q[SYNC_STAGES-1];
  assign sda_n = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h_q <= '1;
      sda_h_q <= '1;
      scl_f_q <= 1'b1;
      sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_n};
      sda_h_q <= {sda_h_q[0], sda_n};
      scl_f_q <= (scl_n & scl_h_q[0]) |
                 (scl_n & scl_h_q[1]) |
                 (scl_h_q[0] & scl_h_q[1]);
      sda_f_q <= (sda_n & sda_h_q[0]) |
                 (sda_n & sda_h_q[1]) |
                 (sda_h_q[0] & sda_h_q[1]);
    end
  end

  assign scl_f = scl_f_q;
  assign sda_f = sda_f_q;
`else
  assign scl_f = scl_sync_q[SYNC_STAGES-1];
  assign sda_f = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  assign start = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d, shift_in;
  logic [7:0] rxd_q, rxd_d, nack_q, nack_d;
  logic       dir_q, dir_d, first_q, first_d;
  logic       oe_q, oe_d, busy_q, busy_d;
  logic       vld_q, vld_d, rfirst_q, rfirst_d;

  assign shift_in = {shift_q[6:0], sda_f};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    rxd_d    = rxd_q;
    nack_d   = nack_q;
    dir_d    = dir_q;
    first_d  = first_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    vld_d    = 1'b0;
    rfirst_d = 1'b0;
    unique case (1'b1)
      start: begin
        state_d  = S_ADDR;
        bitcnt_d = 4'd0;
        oe_d     = 1'b0;
        busy_d   = 1'b0;
      end
      stop: begin
        state_d = S_IDLE;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        case (state_q)
          S_ADDR: if (scl_rise) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              if (shift_in[7:1] == TGT_ADDR) begin
                state_d = S_ACK;
                busy_d  = 1'b1;
                dir_d   = shift_in[0];
                first_d = 1'b1;
              end else begin
                state_d = S_IGNORE;
                if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
              end
            end
          end
          // First fall starts the ACK pulse, second fall ends it.
          S_ACK: if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d     = 1'b0;
              bitcnt_d = 4'd0;
              if (dir_q) begin
                state_d = S_RBYTE;
                shift_d = tx_data;
                oe_d    = ~tx_data[7];
              end else begin
                state_d = S_WBYTE;
              end
            end
          end
          S_WBYTE: if (scl_rise) begin
            shift_d  = shift_in;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              rxd_d    = shift_in;
              vld_d    = 1'b1;
              rfirst_d = first_q;
              first_d  = 1'b0;
              state_d  = S_ACK;
            end
          end
          S_RBYTE: begin
            if (scl_rise) begin
              bitcnt_d = bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                oe_d     = 1'b0;
                bitcnt_d = 4'd0;
                state_d  = S_MACK;
              end else begin
                shift_d = {shift_q[6:0], 1'b0};
                oe_d    = ~shift_q[6];
              end
            end
          end
          // bitcnt=1 marks a master ACK seen; next byte starts on the fall.
          S_MACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                state_d = S_IGNORE;
              end else begin
                shift_d  = tx_data;
                bitcnt_d = 4'd1;
              end
            end else if (scl_fall && bitcnt_q != 4'd0) begin
              state_d  = S_RBYTE;
              oe_d     = ~shift_q[7];
              bitcnt_d = 4'd0;
            end
          end
          default: oe_d = 1'b0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= 4'd0;
      shift_q  <= 8'd0;
      rxd_q    <= 8'd0;
      nack_q   <= 8'd0;
      dir_q    <= 1'b0;
      first_q  <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      rfirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      rxd_q    <= rxd_d;
      nack_q   <= nack_d;
      dir_q    <= dir_d;
      first_q  <= first_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      vld_q    <= vld_d;
      rfirst_q <= rfirst_d;
    end
  end

  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rxd_q;
  assign rx_valid = vld_q;
  assign rx_first = rfirst_q;
  assign busy     = busy_q;
  assign nack_cnt = nack_q;

endmodule
